systolic_feeder: RTL and testbench
==================================

# systolic_feeder

Operand feeder for the 8x8 output-stationary systolic array. It accepts one inner-product step per handshake beat: column k of A and row k of B. It buffers a full job of ARRAY_SIZE beats, then drives the array's left and top edges with the diagonally skewed a/b wavefronts the array expects. It pulses `done` once the last operand pair has reached the bottom-right PE.

## Interface
- DATA_WIDTH, 8, operand width in bits
- ARRAY_SIZE, 8, N; array is N x N, job is N beats
- clk_in  input  1  sole clock, rising edge
- rst  input  1  reset, asynchronous assert, active-low (rst=0 resets)
- in_valid  input  1  load beat offered
- in_ready  output  1  feeder can accept a beat
- in_a_col  input  N*DATA_WIDTH  A[i][k] in slice i (bits i*W +: W)
- in_b_row  input  N*DATA_WIDTH  B[k][j] in slice j
- a_out  output  N*DATA_WIDTH  slice i drives array row i left input
- b_out  output  N*DATA_WIDTH  slice j drives array column j top input
- busy  output  1  job in progress (LOAD/FEED/FLUSH)
- done  output  1  single-cycle pulse: array results complete

## Operation
- Storage: two N x N x W register buffers (A, B), written at beat index k on each accepted beat.
- Beat counter `k` (0..N-1), phase counter `t` (0..3N-1), width clog2(3N).
- States:
  - IDLE: in_ready=1, busy=0, a_out=b_out=0. An accepted beat writes index 0, sets k=1, and moves to LOAD (or straight to FEED if N=1).
  - LOAD: in_ready=1, busy=1. Each accepted beat writes index k and increments k. The beat with k=N-1 moves to FEED with t=1.
  - FEED (t=1..2N-1): in_ready=0.
    - a_out slice i = A[i][t-1-i] when 0 <= t-1-i < N, else 0.
    - b_out slice j = B[t-1-j][j] under the same rule.
    - After t=2N-1, go to FLUSH.
  - FLUSH (t=2N..3N-2): a_out=b_out=0, in_ready=0. After t=3N-2, go to DONE.
  - DONE (t=3N-1): done=1 for exactly this cycle, outputs 0, in_ready=0. The next cycle is IDLE.
- Pure data movement: no arithmetic, values passed bit-exact, no sign handling.
- in_valid while in_ready=0 is ignored; the data is not captured.
- Gaps in in_valid during LOAD are legal. The state holds with no timeout.
- Reset (any state, including mid-FEED) clears state to IDLE, k=t=0, and all outputs to 0 immediately (asynchronous). Buffer contents need not be cleared.

## Timing
- Reset values: in_ready=1, busy=0, done=0, a_out=0, b_out=0.
- All outputs are registered or decoded from registered state; there is no combinational path from in_* to any output.
- in_ready is a function of state only.
- Cycle numbering: c0 = the cycle whose rising edge accepts the last beat.
  - Cycle c0+t: FEED outputs for t=1..2N-1.
  - Array row i receives its first nonzero a in cycle c0+1+i.
  - PE(N-1,N-1) receives its last operand pair in cycle c0+3N-2.
  - done=1 in cycle c0+3N-1 (N=8: c0+23).
  - in_ready returns to 1 in cycle c0+3N.
- Job throughput is N + 3N - 1 cycles minimum (N=8: 31 cycles, with in_valid held high).
- busy=1 from the cycle after the first accepted beat through the DONE cycle inclusive.

## Test plan
- Reset: hold rst=0 with in_valid toggling -> in_ready=1, all other outputs 0. Assert rst asynchronously between edges -> outputs 0 before the next edge.
- Single job, N=8, W=8, A[i][k]=16*i+k, B[k][j]=16*k+j, in_valid held high:
  - c0+1: a row0=0x00, b col0=0x00, all other slices 0.
  - c0+8: a row7=0x70, a row0=0x07.
  - c0+15: only a row7=0x77 and b col7=0x77 nonzero.
  - done pulse at c0+23.
  - Cross-check: feed the stream into the array model; c[i][j] must equal the golden A*B.
- Back-pressure: same data with in_valid deasserted on alternate cycles -> identical a_out/b_out sequence relative to c0; exactly 8 beats captured.
- Ignored input: in_valid=1 with changing data throughout FEED/FLUSH -> output sequence unchanged, next job's beat 0 taken only at c0+24.
- Reset mid-FEED at c0+5 -> outputs 0 immediately, in_ready=1. A following full job runs correctly with no residue from the aborted job.
- Back-to-back: two jobs with distinct data -> two done pulses 31 cycles apart, second wavefront matching the second data set.

Source files
------------

// File: rtl/systolic_feeder.sv
// systolic_feeder: collects one job of ARRAY_SIZE operand beats (column k of A,
// row k of B), then replays them as the diagonally skewed wavefronts that an
// output-stationary N x N systolic array consumes on its left and top edges.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for beat 0 of a job, outputs quiet
// S_LOAD  | capturing beats 1..N-1, gaps in in_valid allowed
// S_FEED  | t = 1..2N-1, skewed operands driven on a_out / b_out
// S_FLUSH | t = 2N..3N-2, edges quiet while the last pairs ripple through
// S_DONE  | t = 3N-1, single-cycle done pulse, back to S_IDLE next cycle
module systolic_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 8
) (
    input  logic                             clk_in,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_a_col,
    input  logic [ARRAY_SIZE*DATA_WIDTH-1:0] in_b_row,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] a_out,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] b_out,
    output logic                             busy,
    output logic                             done
);

    localparam int N  = ARRAY_SIZE;
    localparam int W  = DATA_WIDTH;
    localparam int TW = $clog2(3 * N);
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [TW-1:0] T_ONE        = TW'(1);
    localparam logic [TW-1:0] K_LAST       = TW'(N - 1);
    localparam logic [TW-1:0] T_FEED_LAST  = TW'(2 * N - 1);
    localparam logic [TW-1:0] T_FLUSH_LAST = TW'(3 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FEED,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [TW-1:0]  k_q, k_d;
    logic [TW-1:0]  t_q, t_d;
    logic           accept;

    // a_buf[i][k] = A[i][k], b_buf[k][j] = B[k][j]
    logic [W-1:0]   a_buf_q [N][N];
    logic [W-1:0]   a_buf_d [N][N];
    logic [W-1:0]   b_buf_q [N][N];
    logic [W-1:0]   b_buf_d [N][N];

    // Handshake and status depend on the registered state only.
    assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);

    // Next-state logic: beat counter during loading, phase counter afterwards.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        t_d     = t_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (N == 1) begin
                        state_d = S_FEED;
                        k_d     = '0;
                        t_d     = T_ONE;
                    end else begin
                        state_d = S_LOAD;
                        k_d     = TW'(1);
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (k_q == K_LAST) begin
                        state_d = S_FEED;
                        k_d     = '0;
                        t_d     = T_ONE;
                    end else begin
                        k_d = k_q + TW'(1);
                    end
                end
            end
            S_FEED: begin
                t_d = t_q + T_ONE;
                if (t_q == T_FEED_LAST) begin
                    // a 1x1 array has an empty flush window
                    state_d = (N == 1) ? S_DONE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                t_d = t_q + T_ONE;
                if (t_q == T_FLUSH_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                k_d     = '0;
                t_d     = '0;
            end
            default: begin
                state_d = S_IDLE;
                k_d     = '0;
                t_d     = '0;
            end
        endcase
    end

    // Control registers, cleared asynchronously so a reset aborts any job at once.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            t_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            t_q     <= t_d;
        end
    end

    // Operand capture: an accepted beat lands at index k (k is 0 in IDLE).
    always_comb begin
        a_buf_d = a_buf_q;
        b_buf_d = b_buf_q;
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                a_buf_d[i][k_q[KW-1:0]] = in_a_col[i*W +: W];
                b_buf_d[k_q[KW-1:0]][i] = in_b_row[i*W +: W];
            end
        end
    end

    // Operand storage; a new job always overwrites every entry before use.
    always_ff @(posedge clk_in) begin
        a_buf_q <= a_buf_d;
        b_buf_q <= b_buf_d;
    end

    // Edge g is live for t = g+1 .. g+N and then shows element t-1-g.
    for (genvar g = 0; g < N; g++) begin : g_edge
        localparam logic [TW-1:0] T_LO = TW'(g + 1);
        localparam logic [TW-1:0] T_HI = TW'(g + N);
        logic [KW-1:0] off;
        logic          live;
        assign off  = KW'(t_q - T_LO);
        assign live = (state_q == S_FEED) && (t_q >= T_LO) && (t_q <= T_HI);
        assign a_out[g*W +: W] = live ? a_buf_q[g][off] : '0;
        assign b_out[g*W +: W] = live ? b_buf_q[off][g] : '0;
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: fixed-vector wavefront checks, an array-level
// cross-check against A*B, and a cycle-by-cycle timing model of the feeder.
module tb_systolic_feeder;

    localparam int N    = 8;
    localparam int W    = 8;
    localparam int NW   = N * W;
    localparam int NNW  = N * N * W;
    localparam int TN   = 3 * N;
    localparam int HMAX = 8192;

    logic          clk_in   = 1'b0;
    logic          rst      = 1'b1;
    logic          in_valid = 1'b0;
    logic [NW-1:0] in_a_col = '0;
    logic [NW-1:0] in_b_row = '0;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [NW-1:0] a_out;
    logic [NW-1:0] b_out;

    systolic_feeder #(.DATA_WIDTH(W), .ARRAY_SIZE(N)) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a_col (in_a_col),
        .in_b_row (in_b_row),
        .a_out    (a_out),
        .b_out    (b_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp  = 0;
    int n_fail = 0;

    // ---------------- timing-level reference model ----------------
    // m_e numbers cycles (incremented at each rising edge); a job's c0 is the
    // cycle in which its last beat is presented, its phase is t = m_e - c0.
    int           m_e   = 0;
    bit           m_job = 1'b0;
    int           m_nb  = 0;
    int           m_c0  = -1000;
    logic [W-1:0] m_a [N][N];
    logic [W-1:0] m_b [N][N];
    int           acc_cnt = 0;

    always @(posedge clk_in or negedge rst) begin : model
        bit rdy;
        if (!rst) begin
            m_job = 1'b0;
            m_nb  = 0;
        end else begin
            rdy = !(m_job && (m_e - m_c0) <= TN - 1);
            m_e = m_e + 1;
            if (m_job && (m_e - m_c0) >= TN) begin
                m_job = 1'b0;
                m_nb  = 0;
            end
            if (rdy && in_valid) begin
                for (int i = 0; i < N; i++) begin
                    m_a[i][m_nb] = in_a_col[i*W +: W];
                    m_b[m_nb][i] = in_b_row[i*W +: W];
                end
                m_nb = m_nb + 1;
                if (m_nb == N) begin
                    m_job = 1'b1;
                    m_c0  = m_e - 1;
                end
            end
        end
    end

    always @(posedge clk_in) begin
        if (rst && in_valid && in_ready) acc_cnt++;
    end

    function automatic void exp_out(output logic [NW-1:0] ea, output logic [NW-1:0] eb,
                                    output logic er, output logic ebz, output logic ed);
        int t;
        t   = m_e - m_c0;
        ea  = '0;
        eb  = '0;
        er  = !m_job;
        ebz = m_job || (m_nb > 0);
        ed  = m_job && (t == TN - 1);
        if (m_job && t >= 1 && t <= 2 * N - 1) begin
            for (int i = 0; i < N; i++) begin
                int x;
                x = t - 1 - i;
                if (x >= 0 && x < N) begin
                    ea[i*W +: W] = m_a[i][x];
                    eb[i*W +: W] = m_b[x][i];
                end
            end
        end
    endfunction

    // ---------------- monitor and history ----------------
    logic [NW-1:0] h_a [HMAX];
    logic [NW-1:0] h_b [HMAX];
    logic          h_done [HMAX];
    logic          h_rdy [HMAX];
    int            done_q [$];

    always @(negedge clk_in) begin : monitor
        logic [NW-1:0] ea, eb;
        logic er, ebz, ed;
        if (rst) begin
            exp_out(ea, eb, er, ebz, ed);
            n_cmp++;
            if ({in_ready, busy, done, a_out, b_out} !== {er, ebz, ed, ea, eb}) begin
                n_fail++;
                $display("FAIL monitor cyc=%0d got rdy=%b busy=%b done=%b a=%h b=%h want rdy=%b busy=%b done=%b a=%h b=%h",
                         m_e, in_ready, busy, done, a_out, b_out, er, ebz, ed, ea, eb);
            end
            if (m_e < HMAX) begin
                h_a[m_e]    = a_out;
                h_b[m_e]    = b_out;
                h_done[m_e] = done;
                h_rdy[m_e]  = in_ready;
            end
            if (done === 1'b1) done_q.push_back(m_e);
        end
    end

    // ---------------- fixed wavefront vectors ----------------
    typedef struct {
        int            t;
        logic [NW-1:0] a;
        logic [NW-1:0] b;
        logic          dn;
        logic          rdy;
    } vec_t;

    vec_t tbl [9];

    function automatic logic [NNW-1:0] pat_a();
        logic [NNW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++) v[(i*N+k)*W +: W] = W'(16 * i + k);
        return v;
    endfunction

    function automatic logic [NNW-1:0] pat_b();
        logic [NNW-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++) v[(k*N+j)*W +: W] = W'(16 * k + j);
        return v;
    endfunction

    function automatic logic [NNW-1:0] rand_mat();
        logic [NNW-1:0] v;
        for (int e = 0; e < N * N; e++) v[e*W +: W] = W'($urandom_range(0, 255));
        return v;
    endfunction

    task automatic check_table(input int c0);
        for (int r = 0; r < 9; r++) begin
            int idx;
            idx = c0 + tbl[r].t;
            n_cmp++;
            if (idx < 0 || idx >= HMAX ||
                {h_a[idx], h_b[idx], h_done[idx], h_rdy[idx]} !==
                {tbl[r].a, tbl[r].b, tbl[r].dn, tbl[r].rdy}) begin
                n_fail++;
                if (idx >= 0 && idx < HMAX)
                    $display("FAIL vec t=%0d got a=%h b=%h done=%b rdy=%b want a=%h b=%h done=%b rdy=%b",
                             tbl[r].t, h_a[idx], h_b[idx], h_done[idx], h_rdy[idx],
                             tbl[r].a, tbl[r].b, tbl[r].dn, tbl[r].rdy);
                else
                    $display("FAIL vec t=%0d history index %0d out of range", tbl[r].t, idx);
            end
        end
    endtask

    // Run the recorded edge streams through an output-stationary array:
    // PE(i,j) sees row i's a delayed by j and column j's b delayed by i.
    task automatic check_array(input int c0, input logic [NNW-1:0] A, input logic [NNW-1:0] B,
                               input string name);
        bit bad;
        bad = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint acc, gold;
                acc  = 0;
                gold = 0;
                for (int u = 1; u <= TN - 2; u++) begin
                    int ta, tb;
                    ta = u - j;
                    tb = u - i;
                    if (ta >= 1 && tb >= 1 && c0 + u < HMAX && c0 >= 0)
                        acc += longint'(h_a[c0+ta][i*W +: W]) * longint'(h_b[c0+tb][j*W +: W]);
                end
                for (int k = 0; k < N; k++)
                    gold += longint'(A[(i*N+k)*W +: W]) * longint'(B[(k*N+j)*W +: W]);
                if (acc != gold && !bad) begin
                    bad = 1'b1;
                    $display("FAIL array %s c[%0d][%0d] got %0d want %0d", name, i, j, acc, gold);
                end
            end
        end
        n_cmp++;
        if (bad) n_fail++;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // mode 0: valid whenever ready, 1: alternate cycles, 2: random gaps.
    // noise drives valid with junk data while the feeder is not ready.
    task automatic run_job(input logic [NNW-1:0] A, input logic [NNW-1:0] B, input int mode,
                           input bit noise, output int c0, output int first_acc);
        int b, budget, cur;
        bit go, rs;
        b = 0;
        budget = 0;
        c0 = -1;
        first_acc = -1;
        while (b < N && budget < 400) begin
            @(negedge clk_in);
            budget++;
            case (mode)
                0:       go = 1'b1;
                1:       go = (budget % 2) == 1;
                default: go = ($urandom_range(0, 3) != 0);
            endcase
            rs  = in_ready;
            cur = m_e;
            if (rs && go) begin
                in_valid = 1'b1;
                for (int i = 0; i < N; i++) begin
                    in_a_col[i*W +: W] = A[(i*N+b)*W +: W];
                    in_b_row[i*W +: W] = B[(b*N+i)*W +: W];
                end
            end else begin
                in_valid = (!rs && noise);
                in_a_col = {$urandom(), $urandom()};
                in_b_row = {$urandom(), $urandom()};
            end
            @(posedge clk_in);
            if (in_valid && rs) begin
                if (b == 0) first_acc = cur;
                if (b == N - 1) c0 = cur;
                b++;
            end
        end
        if (b < N) begin
            n_cmp++;
            n_fail++;
            $display("FAIL load_timeout beats=%0d want %0d", b, N);
        end
    endtask

    task automatic wait_until(input int target, input bit noise);
        int g;
        g = 0;
        while (m_e < target && g < 2000) begin
            @(negedge clk_in);
            in_valid = noise && !in_ready;
            in_a_col = {$urandom(), $urandom()};
            in_b_row = {$urandom(), $urandom()};
            g++;
        end
        if (m_e < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_timeout cyc=%0d want %0d", m_e, target);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NNW-1:0] pa, pb, ra, rb, ra2, rb2;
        int c0a, c0b, fa, fb, acc0;

        tbl[0] = '{1,  64'h0, 64'h0, 1'b0, 1'b0};
        tbl[1] = '{2,  64'h0000_0000_0000_1001, 64'h0000_0000_0000_0110, 1'b0, 1'b0};
        tbl[2] = '{8,  64'h7061_5243_3425_1607, 64'h0716_2534_4352_6170, 1'b0, 1'b0};
        tbl[3] = '{9,  64'h7162_5344_3526_1700, 64'h1726_3544_5362_7100, 1'b0, 1'b0};
        tbl[4] = '{15, 64'h7700_0000_0000_0000, 64'h7700_0000_0000_0000, 1'b0, 1'b0};
        tbl[5] = '{16, 64'h0, 64'h0, 1'b0, 1'b0};
        tbl[6] = '{22, 64'h0, 64'h0, 1'b0, 1'b0};
        tbl[7] = '{23, 64'h0, 64'h0, 1'b1, 1'b0};
        tbl[8] = '{24, 64'h0, 64'h0, 1'b0, 1'b1};

        // reset held with in_valid toggling
        #2 rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_in);
            in_valid = ~in_valid;
            in_a_col = {$urandom(), $urandom()};
            in_b_row = {$urandom(), $urandom()};
            #1;
            n_cmp++;
            if ({in_ready, busy, done, a_out, b_out} !== {1'b1, 1'b0, 1'b0, 64'h0, 64'h0}) begin
                n_fail++;
                $display("FAIL reset_hold got rdy=%b busy=%b done=%b a=%h b=%h want rdy=1 busy=0 done=0 a=0 b=0",
                         in_ready, busy, done, a_out, b_out);
            end
        end
        @(negedge clk_in);
        in_valid = 1'b0;
        #1 rst = 1'b1;

        // single job, valid held high
        pa = pat_a();
        pb = pat_b();
        run_job(pa, pb, 0, 1'b0, c0a, fa);
        wait_until(c0a + TN + 1, 1'b0);
        check_table(c0a);
        check_array(c0a, pa, pb, "single");

        // back-pressure: valid on alternate cycles
        acc0 = acc_cnt;
        run_job(pa, pb, 1, 1'b0, c0b, fb);
        wait_until(c0b + TN + 1, 1'b0);
        check_table(c0b);
        check_array(c0b, pa, pb, "backpressure");
        check_int("beats_captured", acc_cnt - acc0, N);

        // back-to-back jobs, junk offered while not ready
        ra  = rand_mat();
        rb  = rand_mat();
        ra2 = rand_mat();
        rb2 = rand_mat();
        done_q.delete();
        run_job(ra, rb, 0, 1'b0, c0a, fa);
        run_job(ra2, rb2, 0, 1'b1, c0b, fb);
        wait_until(c0b + TN + 1, 1'b0);
        check_int("next_beat0_cycle", fb, c0a + TN);
        check_int("job_period", c0b - c0a, 4 * N - 1);
        check_int("done_count", done_q.size(), 2);
        if (done_q.size() == 2) begin
            check_int("done_cycle", done_q[0], c0a + TN - 1);
            check_int("done_spacing", done_q[1] - done_q[0], 4 * N - 1);
        end
        check_array(c0a, ra, rb, "b2b_first");
        check_array(c0b, ra2, rb2, "b2b_second");

        // reset in the middle of FEED
        run_job(ra, rb, 2, 1'b0, c0a, fa);
        in_valid = 1'b0;
        wait_until(c0a + 5, 1'b0);
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, busy, done, a_out, b_out} !== {1'b1, 1'b0, 1'b0, 64'h0, 64'h0}) begin
            n_fail++;
            $display("FAIL async_reset got rdy=%b busy=%b done=%b a=%h b=%h want rdy=1 busy=0 done=0 a=0 b=0",
                     in_ready, busy, done, a_out, b_out);
        end
        @(negedge clk_in);
        @(negedge clk_in);
        #1 rst = 1'b1;
        ra = rand_mat();
        rb = rand_mat();
        run_job(ra, rb, 2, 1'b1, c0b, fb);
        wait_until(c0b + TN + 1, 1'b0);
        check_array(c0b, ra, rb, "after_reset");

        // random jobs with random gaps and junk
        for (int r = 0; r < 4; r++) begin
            ra = rand_mat();
            rb = rand_mat();
            run_job(ra, rb, 2, bit'($urandom_range(0, 1)), c0a, fa);
            wait_until(c0a + TN + 1, 1'b1);
            check_array(c0a, ra, rb, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
